// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with a valid/ready handshake,
// an illegal-op flag and a fixed-latency mult/div sequencer.
// Single-cycle ops produce a one-cycle valid_o pulse on the cycle after acceptance.
// A mult/div op blocks new ops (ready_o=0) until its result pulse, which comes
// MD_LAT cycles after acceptance.
// Optional macro ALU_CTRL_PERF_EN adds the saturating perf_ops_o / perf_stall_o counters.
module alu_ctrl_seq #(
  parameter int OP_W   = 3,
  parameter int CTRL_W = 4,
  parameter int MD_LAT = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [5:0]        Funct,
  input  logic [OP_W-1:0]   ALU_OP,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ALU_Ctrl_Out,
  output logic              illegal_o,
  output logic              md_start_o,
`ifdef ALU_CTRL_PERF_EN
  output logic [15:0]       perf_ops_o,
  output logic [15:0]       perf_stall_o,
`endif
  output logic              md_busy_o
);

  localparam int CNT_W = $clog2(MD_LAT) + 1;

  typedef enum logic {IDLE = 1'b0, MD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_d, ill_d, start_d, busy_d;
  logic [CTRL_W-1:0]  ctrl_d;
  logic [CTRL_W-1:0]  dec_code;
  logic               dec_ill, dec_md;
  logic [31:0]        op_ext;
  logic               accept;

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i && ready_o;

  // Decode ALU_OP / Funct into a control code; illegal ops decode to code 0.
  always_comb begin
    dec_code = '0;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    op_ext   = 32'(ALU_OP);
    case (op_ext)
      32'd0: dec_code = CTRL_W'(4'b0010);
      32'd1: dec_code = CTRL_W'(4'b0110);
      32'd2: begin
        case (Funct)
          6'b100000, 6'b100001: dec_code = CTRL_W'(4'b0010);
          6'b100010, 6'b100011: dec_code = CTRL_W'(4'b0110);
          6'b100100:            dec_code = CTRL_W'(4'b0000);
          6'b100101:            dec_code = CTRL_W'(4'b0001);
          6'b100111:            dec_code = CTRL_W'(4'b1100);
          6'b101010:            dec_code = CTRL_W'(4'b0111);
          6'b000000:            dec_code = CTRL_W'(4'b1000);
          6'b000010:            dec_code = CTRL_W'(4'b1001);
          6'b011000: begin      dec_code = CTRL_W'(4'b1010); dec_md = 1'b1; end
          6'b011010: begin      dec_code = CTRL_W'(4'b1011); dec_md = 1'b1; end
          default:              dec_ill  = 1'b1;
        endcase
      end
      32'd3: dec_code = CTRL_W'(4'b0000);
      32'd4: dec_code = CTRL_W'(4'b0001);
      32'd5: dec_code = CTRL_W'(4'b0111);
      default: dec_ill = 1'b1;
    endcase
  end

  // Next-state and next-output logic; outputs are registered for 1-cycle latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    ill_d   = 1'b0;
    start_d = 1'b0;
    busy_d  = md_busy_o;
    ctrl_d  = ALU_Ctrl_Out;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ctrl_d = dec_code;
          if (dec_md) begin
            state_d = MD;
            start_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(1);
          end else begin
            valid_d = 1'b1;
            ill_d   = dec_ill;
          end
        end
      end
      MD: begin
        // Result pulse lands MD_LAT cycles after the accept edge.
        if (cnt_q == CNT_W'(MD_LAT - 1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over a same-edge accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_o      <= 1'b0;
      ALU_Ctrl_Out <= '0;
      illegal_o    <= 1'b0;
      md_start_o   <= 1'b0;
      md_busy_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_o      <= valid_d;
      ALU_Ctrl_Out <= ctrl_d;
      illegal_o    <= ill_d;
      md_start_o   <= start_d;
      md_busy_o    <= busy_d;
    end
  end

`ifdef ALU_CTRL_PERF_EN
  // Saturating counters of accepted ops and of stalled request cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_ops_o   <= '0;
      perf_stall_o <= '0;
    end else begin
      if (accept && perf_ops_o != 16'hFFFF)
        perf_ops_o <= perf_ops_o + 16'd1;
      if (valid_i && !ready_o && perf_stall_o != 16'hFFFF)
        perf_stall_o <= perf_stall_o + 16'd1;
    end
  end
`endif

endmodule
